// File: rtl/stopwatch_control.sv
// Stopwatch control: debounced start/stop and lap/reset buttons driving a 4-state run/lap FSM.
// Optional hour-limit stop is enabled by defining STOPWATCH_HOUR_STOP_EN.
module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_lap_reset,
    input  logic       hour_pulse,
    output logic       run,
    output logic       clear,
    output logic       lap_hold,
    output logic [1:0] state,
    output logic       overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        LAP     = 2'b11
    } state_t;

    state_t           st;
    logic [1:0]       raw;
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       db_lvl;
    logic [1:0]       db_prev;
    logic [CNT_W-1:0] db_cnt [2];

    logic start_press, lap_press;
    logic start_ev, lap_ev;
    logic hour_stop;

    assign raw = {btn_lap_reset, btn_start_stop};

    // Synchroniser stages, then a per-button counter that must see the new level
    // DEBOUNCE_CYCLES times in a row before the debounced level follows it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            db_prev <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= CNT_LAST) begin
                    db_lvl[i] <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign start_press = db_lvl[0] & ~db_prev[0];
    assign lap_press   = db_lvl[1] & ~db_prev[1];

`ifdef STOPWATCH_HOUR_STOP_EN
    assign hour_stop = hour_pulse && (st == RUNNING || st == LAP);
    // Once stopped at the hour limit, only a clear can restart the sequence.
    assign start_ev  = start_press && !(st == PAUSED && overflow);
`else
    logic unused_hour;
    assign unused_hour = hour_pulse;
    assign hour_stop   = 1'b0;
    assign start_ev    = start_press;
`endif

    assign lap_ev = lap_press && !start_ev;
    assign state  = st;

    always_ff @(posedge clock) begin
        if (reset) begin
            st       <= IDLE;
            run      <= 1'b0;
            clear    <= 1'b0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
        end else begin
            clear <= 1'b0;
            if (hour_stop) begin
                st       <= PAUSED;
                run      <= 1'b0;
                lap_hold <= 1'b0;
                overflow <= 1'b1;
            end else begin
                case (st)
                    IDLE: begin
                        if (start_ev) begin
                            st  <= RUNNING;
                            run <= 1'b1;
                        end else if (lap_ev) begin
                            clear    <= 1'b1;
                            overflow <= 1'b0;
                        end
                    end
                    RUNNING: begin
                        if (start_ev) begin
                            st  <= PAUSED;
                            run <= 1'b0;
                        end else if (lap_ev) begin
                            st       <= LAP;
                            lap_hold <= 1'b1;
                        end
                    end
                    LAP: begin
                        if (start_ev) begin
                            st       <= PAUSED;
                            run      <= 1'b0;
                            lap_hold <= 1'b0;
                        end else if (lap_ev) begin
                            st       <= RUNNING;
                            lap_hold <= 1'b0;
                        end
                    end
                    default: begin
                        if (start_ev) begin
                            st  <= RUNNING;
                            run <= 1'b1;
                        end else if (lap_ev) begin
                            st       <= IDLE;
                            clear    <= 1'b1;
                            overflow <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
